// File: rtl/alu_core_pkg.sv
// Shared opcode encoding and instruction field layout for the pipelined ALU core.
// Instruction format, MSB to LSB: {op[1:0], rd, rs1, rs2}, each register field REG_AW bits.
package alu_core_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_LDI = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    localparam int FLD_RS2 = 0;
    localparam int FLD_RS1 = 1;
    localparam int FLD_RD  = 2;
    localparam int FLD_OP  = 3;

    // LSB position of a field, counted in register-index-sized slots
    function automatic int field_lsb(input int reg_aw, input int fld);
        return fld * reg_aw;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two combinational read ports, one write port, synchronous clear.
// Reads see a same-edge write to the same index (write-through).
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];

    // storage array: cleared on reset, one write per cycle otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/pipelined_alu_core.sv
// Four-stage in-order ALU pipeline (IF, ID, EX, WB) with register file, full
// operand forwarding and valid/ready handshakes on instruction input and result output.
module pipelined_alu_core
    import alu_core_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int REG_AW  = 3,
    localparam int INSTR_W = 2 + 3 * REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DATA_W-1:0]  res,
    output logic [REG_AW-1:0]  res_rd,
    output logic               res_valid,
    input  logic               out_ready
);

    localparam int RS2_LSB = field_lsb(REG_AW, FLD_RS2);
    localparam int RS1_LSB = field_lsb(REG_AW, FLD_RS1);
    localparam int RD_LSB  = field_lsb(REG_AW, FLD_RD);
    localparam int OP_LSB  = field_lsb(REG_AW, FLD_OP);

    logic               stall_s;

    logic               if_valid_q;
    logic               if_valid_d;
    logic [INSTR_W-1:0] if_instr_q;
    op_e                if_op_s;
    logic [REG_AW-1:0]  if_rd_s;
    logic [REG_AW-1:0]  if_rs1_s;
    logic [REG_AW-1:0]  if_rs2_s;

    logic               id_valid_q;
    op_e                id_op_q;
    logic [REG_AW-1:0]  id_rd_q;
    logic [REG_AW-1:0]  id_rs1_q;
    logic [REG_AW-1:0]  id_rs2_q;
    logic [DATA_W-1:0]  id_a_q;
    logic [DATA_W-1:0]  id_b_q;

    logic [DATA_W-1:0]  rf_a_s;
    logic [DATA_W-1:0]  rf_b_s;
    logic               rf_we_s;

    logic [DATA_W-1:0]  op_a_s;
    logic [DATA_W-1:0]  op_b_s;
    logic [DATA_W-1:0]  ex_res_d;

    logic               ex_valid_q;
    logic [REG_AW-1:0]  ex_rd_q;
    logic [DATA_W-1:0]  ex_res_q;

    logic               res_valid_q;
    logic [DATA_W-1:0]  res_q;
    logic [REG_AW-1:0]  res_rd_q;

    assign stall_s     = res_valid_q & ~out_ready;
    assign instr_ready = ~stall_s;

    // NOPs enter as bubbles so nothing downstream needs to look at their opcode
    assign if_valid_d = instr_valid & (instr[OP_LSB +: 2] != OP_NOP);

    assign if_op_s  = op_e'(if_instr_q[OP_LSB +: 2]);
    assign if_rd_s  = if_instr_q[RD_LSB +: REG_AW];
    assign if_rs1_s = if_instr_q[RS1_LSB +: REG_AW];
    assign if_rs2_s = if_instr_q[RS2_LSB +: REG_AW];

    // the write lands on the same edge that WB loads the result register
    assign rf_we_s = ex_valid_q & ~stall_s;

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we_s),
        .waddr_i   (ex_rd_q),
        .wdata_i   (ex_res_q),
        .raddr_a_i (if_rs1_s),
        .rdata_a_o (rf_a_s),
        .raddr_b_i (if_rs2_s),
        .rdata_b_o (rf_b_s)
    );

    // EX operand selection: nearest older producer wins
    always_comb begin
        op_a_s = id_a_q;
        op_b_s = id_b_q;
        if (ex_valid_q && (ex_rd_q == id_rs1_q)) begin
            op_a_s = ex_res_q;
        end else if (res_valid_q && (res_rd_q == id_rs1_q)) begin
            op_a_s = res_q;
        end else begin
            op_a_s = id_a_q;
        end
        if (ex_valid_q && (ex_rd_q == id_rs2_q)) begin
            op_b_s = ex_res_q;
        end else if (res_valid_q && (res_rd_q == id_rs2_q)) begin
            op_b_s = res_q;
        end else begin
            op_b_s = id_b_q;
        end
    end

    // execute: modulo arithmetic, immediate is the two source fields zero-extended
    always_comb begin
        ex_res_d = {DATA_W{1'b0}};
        case (id_op_q)
            OP_ADD:  ex_res_d = op_a_s + op_b_s;
            OP_SUB:  ex_res_d = op_a_s - op_b_s;
            OP_LDI:  ex_res_d = DATA_W'({id_rs1_q, id_rs2_q});
            default: ex_res_d = {DATA_W{1'b0}};
        endcase
    end

    // pipeline registers: cleared on reset, frozen as a whole while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q  <= 1'b0;
            if_instr_q  <= {INSTR_W{1'b0}};
            id_valid_q  <= 1'b0;
            id_op_q     <= OP_NOP;
            id_rd_q     <= {REG_AW{1'b0}};
            id_rs1_q    <= {REG_AW{1'b0}};
            id_rs2_q    <= {REG_AW{1'b0}};
            id_a_q      <= {DATA_W{1'b0}};
            id_b_q      <= {DATA_W{1'b0}};
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= {REG_AW{1'b0}};
            ex_res_q    <= {DATA_W{1'b0}};
            res_valid_q <= 1'b0;
            res_q       <= {DATA_W{1'b0}};
            res_rd_q    <= {REG_AW{1'b0}};
        end else if (!stall_s) begin
            if_valid_q  <= if_valid_d;
            if_instr_q  <= instr;
            id_valid_q  <= if_valid_q;
            id_op_q     <= if_op_s;
            id_rd_q     <= if_rd_s;
            id_rs1_q    <= if_rs1_s;
            id_rs2_q    <= if_rs2_s;
            id_a_q      <= rf_a_s;
            id_b_q      <= rf_b_s;
            ex_valid_q  <= id_valid_q;
            ex_rd_q     <= id_rd_q;
            ex_res_q    <= ex_res_d;
            res_valid_q <= ex_valid_q;
            res_q       <= ex_res_q;
            res_rd_q    <= ex_rd_q;
        end
    end

    assign res       = res_q;
    assign res_rd    = res_rd_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Self-checking bench for pipelined_alu_core: cycle-exact vector table, directed
// backpressure/reset sequences, and random traffic against a sequential ISA model.
module tb_pipelined_alu_core;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 3;
    localparam int INSTR_W = 2 + 3 * REG_AW;
    localparam int MOD     = 1 << DATA_W;

    logic               clk;
    logic               rst;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [DATA_W-1:0]  res;
    logic [REG_AW-1:0]  res_rd;
    logic               res_valid;
    logic               out_ready;

    pipelined_alu_core #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .res         (res),
        .res_rd      (res_rd),
        .res_valid   (res_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               v;
        logic [INSTR_W-1:0] ins;
        int                 exp_rv;
        int                 exp_res;
        int                 exp_rd;
    } vec_t;

    typedef struct {
        int res;
        int rd;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   regs_m[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic              s_rdy;
    logic              s_rv;
    logic [DATA_W-1:0] s_res;
    logic [REG_AW-1:0] s_rd;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {op[1:0], rd[2:0], rs1[2:0], rs2[2:0]};
    endfunction

    function automatic logic [INSTR_W-1:0] ldi(input int rd, input int val);
        return mk(2, rd, val / 8, val % 8);
    endfunction

    // ISA-level model: instructions take effect in program order at acceptance
    task automatic model_accept(input logic [INSTR_W-1:0] ins);
        int op, rd, a, b, r;
        exp_t e;
        op = int'(ins[10:9]);
        rd = int'(ins[8:6]);
        a  = int'(ins[5:3]);
        b  = int'(ins[2:0]);
        if (op != 3) begin
            case (op)
                0:       r = (regs_m[a] + regs_m[b]) % MOD;
                1:       r = ((regs_m[a] - regs_m[b]) % MOD + MOD) % MOD;
                default: r = a * 8 + b;
            endcase
            regs_m[rd] = r;
            e.res = r;
            e.rd  = rd;
            sbq.push_back(e);
        end
    endtask

    // one clock cycle: drive, sample before the edge, update scoreboard, advance
    task automatic tick(input logic r, input logic v, input logic [INSTR_W-1:0] ins, input logic ordy);
        exp_t e;
        rst = r; instr_valid = v; instr = ins; out_ready = ordy;
        #1;
        s_rdy = instr_ready; s_rv = res_valid; s_res = res; s_rd = res_rd;
        if (r) begin
            sbq.delete();
            foreach (regs_m[i]) regs_m[i] = 0;
        end else begin
            if (s_rv && ordy) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_extra: res=%0d rd=%0d retired, expected no result", s_res, s_rd);
                end else begin
                    e = sbq.pop_front();
                    check("sb_res", int'(s_res), e.res);
                    check("sb_rd", int'(s_rd), e.rd);
                end
            end
            if (v && s_rdy) model_accept(ins);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic v, input logic [INSTR_W-1:0] ins, input int rv, input int rs, input int rd);
        vec_t t;
        t.v = v; t.ins = ins; t.exp_rv = rv; t.exp_res = rs; t.exp_rd = rd;
        tbl.push_back(t);
    endtask

    task automatic idle(input int rv, input int rs, input int rd);
        row(1'b0, mk(0, 7, 7, 7), rv, rs, rd);
    endtask

    initial begin
        int hold, next, delivered, lat;
        logic ordy, r, v, prev_rst;
        logic [INSTR_W-1:0] rins;

        rst = 1'b1; instr_valid = 1'b0; instr = '0; out_ready = 1'b1;
        foreach (regs_m[i]) regs_m[i] = 0;
        tick(1'b1, 1'b0, '0, 1'b1);
        tick(1'b1, 1'b0, '0, 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        check("rst_res_valid", int'(s_rv), 0);
        check("rst_instr_ready", int'(s_rdy), 1);
        check("rst_res", int'(s_res), 0);
        check("rst_res_rd", int'(s_rd), 0);

        // immediates
        row(1'b1, ldi(1, 5), 0, 0, 0); row(1'b1, ldi(2, 3), 0, 0, 0);
        idle(0, 0, 0); idle(0, 0, 0); idle(1, 5, 1); idle(1, 3, 2); idle(0, 0, 0);
        // back-to-back forwarding
        row(1'b1, ldi(1, 5), 0, 0, 0); row(1'b1, ldi(2, 3), 0, 0, 0);
        row(1'b1, mk(0, 3, 1, 2), 0, 0, 0); row(1'b1, mk(1, 4, 3, 1), 0, 0, 0);
        idle(1, 5, 1); idle(1, 3, 2); idle(1, 8, 3); idle(1, 3, 4); idle(0, 0, 0);
        // modulo wrap, chained through forwarding
        row(1'b1, ldi(1, 63), 0, 0, 0); row(1'b1, mk(0, 2, 1, 1), 0, 0, 0);
        row(1'b1, mk(0, 2, 2, 2), 0, 0, 0); row(1'b1, mk(0, 3, 2, 1), 0, 0, 0);
        row(1'b1, ldi(0, 0), 1, 63, 1); row(1'b1, ldi(1, 1), 1, 126, 2);
        row(1'b1, mk(1, 0, 0, 1), 1, 252, 2);
        idle(1, 59, 3); idle(1, 0, 0); idle(1, 1, 1); idle(1, 255, 0); idle(0, 0, 0);
        // bubble and NOP
        row(1'b1, ldi(1, 7), 0, 0, 0); idle(0, 0, 0);
        row(1'b1, mk(3, 2, 1, 1), 0, 0, 0); row(1'b1, mk(0, 2, 1, 1), 0, 0, 0);
        idle(1, 7, 1); idle(0, 0, 0); idle(0, 0, 0); idle(1, 14, 2); idle(0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            tick(1'b0, tbl[i].v, tbl[i].ins, 1'b1);
            check($sformatf("vec%0d_ready", i), int'(s_rdy), 1);
            check($sformatf("vec%0d_valid", i), int'(s_rv), tbl[i].exp_rv);
            if (tbl[i].exp_rv != 0) begin
                check($sformatf("vec%0d_res", i), int'(s_res), tbl[i].exp_res);
                check($sformatf("vec%0d_rd", i), int'(s_rd), tbl[i].exp_rd);
            end
        end

        // backpressure: 6 LDIs, consumer refuses the first result for 3 cycles
        hold = 0; next = 1; delivered = 0;
        for (int c = 0; c < 40 && delivered < 6; c++) begin
            ordy = 1'b1;
            if (res_valid && hold < 3) begin
                ordy = 1'b0;
                hold++;
            end
            tick(1'b0, next <= 6, ldi(next, next), ordy);
            if (!ordy) begin
                check("bp_ready_low", int'(s_rdy), 0);
                check("bp_hold_valid", int'(s_rv), 1);
                check("bp_hold_res", int'(s_res), 1);
            end else if (s_rv) begin
                check("bp_order", int'(s_res), delivered + 1);
                delivered++;
            end else if (delivered > 0) begin
                check("bp_no_gap", int'(s_rv), 1);
            end
            if (next <= 6 && s_rdy) next++;
        end
        check("bp_delivered", delivered, 6);
        check("bp_stall_cycles", hold, 3);

        // reset with three instructions in flight
        tick(1'b0, 1'b1, ldi(1, 9), 1'b1);
        tick(1'b0, 1'b1, ldi(2, 4), 1'b1);
        tick(1'b0, 1'b1, ldi(3, 2), 1'b1);
        tick(1'b1, 1'b1, ldi(4, 33), 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        check("mid_rst_valid", int'(s_rv), 0);
        check("mid_rst_res", int'(s_res), 0);
        check("mid_rst_rd", int'(s_rd), 0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            check("mid_rst_discard", int'(s_rv), 0);
        end
        tick(1'b0, 1'b1, mk(0, 5, 1, 2), 1'b1);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            if (s_rv) begin
                lat = k;
                check("post_rst_add_res", int'(s_res), 0);
                check("post_rst_add_rd", int'(s_rd), 5);
            end
        end
        check("post_rst_add_latency", lat, 4);

        // random traffic with backpressure and occasional reset
        prev_rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            r    = ($urandom_range(0, 79) == 0);
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            rins = INSTR_W'($urandom);
            tick(r, v, rins, ordy);
            if (prev_rst) check("rand_post_rst_valid", int'(s_rv), 0);
            check("rand_ready", int'(s_rdy), int'(!(s_rv && !ordy)));
            prev_rst = r;
        end
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
        end
        check("rand_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_alu_core.md
Name: pipelined_alu_core

Overview:
- Parametrised four-stage in-order ALU pipeline (IF, ID, EX, WB), the next generation of the team's 8-bit fetch/decode/execute/writeback core.
- Adds a register file, full operand forwarding, per-stage valid bits and valid/ready handshakes on both instruction input and result output.
- Sits between an instruction source (sequencer or testbench FIFO) and a result consumer. Throughput is one instruction per cycle when not back-pressured.

Parameters:
DATA_W, 8, datapath and register width in bits; must be >= 2*REG_AW.
REG_AW, 3, register index width; the register file has 2**REG_AW entries.
INSTR_W, 2+3*REG_AW (derived, localparam), instruction width.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  reset, synchronous, active-high.
instr  input  INSTR_W  instruction, format {op[1:0], rd, rs1, rs2}.
instr_valid  input  1  instr is valid this cycle.
instr_ready  output  1  core accepts instr on this edge when instr_valid is also high.
res  output  DATA_W  result of the retired instruction.
res_rd  output  REG_AW  destination register of the retired instruction.
res_valid  output  1  res and res_rd are valid.
out_ready  input  1  consumer accepts res on this edge.

Behaviour:
- Opcodes: ADD=00, rd=rs1+rs2. SUB=01, rd=rs1-rs2. LDI=10, rd=zero-extended {rs1,rs2} immediate (2*REG_AW bits). NOP=11, no register write, no result.
- Arithmetic is modulo 2**DATA_W. No flags. Register 0 is an ordinary register.
- Stages: IF captures instr. ID reads rs1/rs2 from the register file. EX computes. WB drives res/res_rd/res_valid and writes rd in the register file on the same edge.
- Each stage carries a valid bit. Invalid stages and NOPs never write the register file or forward. A NOP propagates as invalid; it produces no res_valid.
- Latency: an instruction accepted at edge N has its result registered at edge N+3, so res_valid is high during the cycle after N+3.
- Forwarding (no hazard stalls ever), EX operand source per rs, in priority order:
  1. EX/WB register, if valid, writing, and rd matches (producer one ahead).
  2. WB output register, if valid, writing, and rd matches (producer two ahead).
  3. The ID/EX captured value.
- Producer three ahead: the ID register-file read is write-through, so a same-edge WB write to that index is seen.
- Stall: stall = res_valid & ~out_ready. While stalled, every stage register and the register file hold. instr_ready = ~stall (combinational); no instruction is lost or duplicated.
- Empty pipeline: res_valid=0; instr_ready=1.
- Reset: on any edge with rst=1, all valid bits, the register file, res and res_rd go to 0. res_valid=0 in the following cycle. In-flight instructions are discarded, including mid-stall. instr is ignored on that edge.
- instr_valid=0 inserts a bubble; downstream stages keep advancing unless stalled.

Decomposition:
- Shared package alu_core_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_LDI, OP_NOP;
  - a field-extract helper or localparams for the op/rd/rs1/rs2 bit positions, given REG_AW.
- One sub-module, alu_regfile: 2**REG_AW x DATA_W, two combinational read ports, one write port, write-through bypass, synchronous reset clear.

Test Plan:
- Instruction notation is {op,rd,rs1,rs2}, defaults, out_ready=1.
- Immediate: LDI r1=5, then LDI r2=3, with no other instructions in flight -> r1 result valid 4 cycles after acceptance: res=5, res_rd=1; next cycle res=3, res_rd=2.
- Back-to-back forwarding: LDI r1=5, LDI r2=3, ADD r3=r1+r2, SUB r4=r3-r1 on consecutive cycles -> results 5,3,8,3 in consecutive cycles, with no stalls.
- Wrap: LDI r1=63, ADD r2=r1+r1 (x4 via chained ADDs to 252), then ADD r3=r2+r1 -> r3 = (252+63) mod 256 = 59. Separately, SUB r0=r0-r1 with r0=0, r1=1 -> 255.
- Backpressure: stream 6 LDIs with values 1..6, hold out_ready=0 for 3 cycles once res_valid=1 -> instr_ready=0 during the stall, res holds 1, then 1..6 delivered in order, with no gaps after release.
- Bubbles and NOP: LDI r1=7, an idle cycle, NOP, ADD r2=r1+r1 -> exactly two res_valid pulses, res=7 then 14.
- Reset mid-flight: assert rst for 1 cycle with 3 instructions in flight -> res_valid=0 next cycle, no results emitted; a subsequent ADD r5=r1+r2 returns 0.
